reg_file_sb: RTL
================

# reg_file_sb

Architectural register file with an integrated scoreboard, sitting directly upstream of the ALU. It supplies the two ALU source operands `regA`/`regB` and accepts the write-back result, which is the ALU `regD` or the memory load data. A per-register pending bit tracks destinations of outstanding multi-cycle operations such as loads. When a source operand is not yet valid, the block raises `stall` to the control unit.

## Interface

Parameters:
- `DATA_W`, default `` `REG_FILE_WIDTH `` (32): register width.
- `ADDR_W`, default `` `REG_ADDR_WIDTH `` (5): register index width.
- `NUM_REGS`, default `` `NUM_REGS `` (32): number of registers, equal to 2^ADDR_W.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `rd_addr_a`  in  ADDR_W  source A index.
- `rd_addr_b`  in  ADDR_W  source B index.
- `use_a`  in  1  the instruction actually reads source A.
- `use_b`  in  1  the instruction actually reads source B.
- `regA`  out  DATA_W  source A value, to the ALU.
- `regB`  out  DATA_W  source B value, to the ALU.
- `wr_en`  in  1  write-back valid.
- `wr_addr`  in  ADDR_W  write-back index.
- `wr_data`  in  DATA_W  write-back value.
- `pend_set`  in  1  a multi-cycle op targeting `pend_addr` issues this cycle.
- `pend_addr`  in  ADDR_W  destination index of that op.
- `stall`  out  1  a used source is pending and not satisfied by this cycle's write.

## Operation

- **Register 0:** hardwired to zero. Writes to r0 are ignored, `pend_set` to r0 is ignored, and reads of r0 return 0.
- **Read path:** combinational. Each read port returns the register contents, except that when `wr_en` is high and `wr_addr` equals the read index (and the index is not 0), the port returns `wr_data`. This is write-to-read bypass.
- **Write:** at the clock edge, if `wr_en` is high and `wr_addr` is not 0, the register is set to `wr_data`.
- **Scoreboard:** one pending bit per register.
  - Set at the edge when `pend_set` is high for a nonzero `pend_addr`.
  - Cleared at the edge by a write (`wr_en`) to that index.
  - If the set and the clear target the same index in the same cycle, set wins. The new op is younger than the completing one.
- **Stall:** `stall = (use_a & pend[a] & ~byp_a) | (use_b & pend[b] & ~byp_b)`.
  - `byp_x` means a write to index x is present this cycle.
  - A source that is not used never stalls.
  - r0 never stalls.
- **Stall does not gate anything internally.** The control unit must hold the instruction and must not assert `pend_set` for a stalled instruction. The block does not check this.
- **Reset:** all registers become 0 and all pending bits become 0. A reset while loads are outstanding discards them. A later write to the same index is still accepted and clears nothing harmful.
- **Widths:** no arithmetic is performed. Data passes through at `DATA_W` unchanged.

## Timing

- **Read latency:** 0 cycles, combinational from address, write port and pending state.
- **Write latency:** the value is visible on the same cycle through bypass and from the array on the next cycle.
- **`pend_set` in cycle N:** a dependent instruction in cycle N+1 sees `stall` = 1. A dependent instruction in cycle N itself does not stall, because its producer is in the same instruction.
- **Pending clear:** a write in cycle M clears `stall` combinationally in cycle M (bypass) and via the pending bit from cycle M+1.
- **Outputs after reset:** `regA` = 0 and `regB` = 0 for any index with no concurrent write; `stall` = 0.
- **Reset precedence:** reset has priority over `wr_en` and `pend_set` in the same cycle.

## Structure

- Shared `header.vh` holds the constants.
  - Existing: `REG_FILE_WIDTH` (32).
  - Add: `REG_ADDR_WIDTH` (5) and `NUM_REGS` (32).
- One sub-module, `reg_scoreboard`: the pending-bit vector with its set/clear logic, two lookup outputs, and the stall equation.
- The top level holds the data array and the bypass muxes.

## Test plan

- **Reset state:** assert `reset` for 1 cycle, then sweep `rd_addr_a` and `rd_addr_b` over 0..31 → every read returns 0 and `stall` = 0.
- **Bypass and write:**
  - Cycle N: `wr_en` = 1, `wr_addr` = 5, `wr_data` = 0xDEADBEEF, `rd_addr_a` = 5 → `regA` = 0xDEADBEEF in cycle N.
  - Cycle N+1, with `wr_en` = 0 → `regA` = 0xDEADBEEF.
- **r0 protection:** write 0x12345678 to r0 and assert `pend_set` to r0, then read r0 with `use_a` = 1 → `regA` = 0 and `stall` = 0, both in the same cycle and in the next.
- **Load-use stall:**
  - Cycle 0: `pend_set` to r3.
  - Cycle 1: `rd_addr_b` = 3, `use_b` = 1 → `stall` = 1.
  - Cycle 1 with `use_b` = 0 instead → `stall` = 0.
  - Cycle 4: write r3 = 0xA5 → `stall` = 0 and `regB` = 0xA5 in cycle 4.
  - Cycle 5: `stall` = 0.
- **Simultaneous set and clear:** in cycle N, write r7 = 1 and `pend_set` r7 → in cycle N+1, reading r7 with `use_a` = 1 gives `stall` = 1 and `regA` = 1.
- **Reset mid-operation:** `pend_set` r9, then `reset` one cycle later → after reset, reading r9 with `use_a` = 1 gives `stall` = 0 and `regA` = 0.

Source files
------------

// File: rtl/reg_file_sb_pkg.sv
// Shared constants for the register file / scoreboard slice.
// Default widths and register count used by reg_file_sb and reg_scoreboard.
package reg_file_sb_pkg;

    localparam int REG_FILE_WIDTH = 32;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int NUM_REGS       = 32;

endpackage

// File: rtl/reg_file_sb_scoreboard.sv
// reg_scoreboard: one pending bit per architectural register plus the stall equation.
// A pending bit is set by a multi-cycle issue and cleared by the matching write-back.
module reg_scoreboard
    import reg_file_sb_pkg::*;
#(
    parameter int ADDR_W   = REG_ADDR_WIDTH,
    parameter int NUM_REGS = reg_file_sb_pkg::NUM_REGS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              pend_set,
    input  logic [ADDR_W-1:0] pend_addr,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    input  logic              use_a,
    input  logic              use_b,
    output logic              stall
);

    logic [NUM_REGS-1:0] pend_q;
    logic [NUM_REGS-1:0] pend_d;
    logic                pend_a;
    logic                pend_b;
    logic                byp_a;
    logic                byp_b;

    // Clear is applied before set so a younger issue to the same index survives.
    always_comb begin
        pend_d = pend_q;
        if (wr_en) begin
            pend_d[wr_addr] = 1'b0;
        end
        if (pend_set && (pend_addr != '0)) begin
            pend_d[pend_addr] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign pend_a = pend_q[rd_addr_a];
    assign pend_b = pend_q[rd_addr_b];
    assign byp_a  = wr_en && (wr_addr == rd_addr_a);
    assign byp_b  = wr_en && (wr_addr == rd_addr_b);

    // r0 never has its pending bit set, so it can never stall.
    assign stall = (use_a && pend_a && !byp_a) || (use_b && pend_b && !byp_b);

endmodule

// File: rtl/reg_file_sb.sv
// Architectural register file with write-to-read bypass and an integrated scoreboard.
// Supplies ALU operands combinationally and flags stalls on pending sources.
module reg_file_sb
    import reg_file_sb_pkg::*;
#(
    parameter int DATA_W   = REG_FILE_WIDTH,
    parameter int ADDR_W   = REG_ADDR_WIDTH,
    parameter int NUM_REGS = reg_file_sb_pkg::NUM_REGS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    input  logic              use_a,
    input  logic              use_b,
    output logic [DATA_W-1:0] regA,
    output logic [DATA_W-1:0] regB,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              pend_set,
    input  logic [ADDR_W-1:0] pend_addr,
    output logic              stall
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic              wr_live;

    assign wr_live = wr_en && (wr_addr != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_live) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    // r0 reads as zero regardless of the array; a same-cycle write wins over the array.
    always_comb begin
        regA = regs_q[rd_addr_a];
        regB = regs_q[rd_addr_b];
        if (wr_live && (wr_addr == rd_addr_a)) begin
            regA = wr_data;
        end
        if (wr_live && (wr_addr == rd_addr_b)) begin
            regB = wr_data;
        end
        if (rd_addr_a == '0) begin
            regA = '0;
        end
        if (rd_addr_b == '0) begin
            regB = '0;
        end
    end

    reg_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) u_scoreboard (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .pend_set  (pend_set),
        .pend_addr (pend_addr),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .use_a     (use_a),
        .use_b     (use_b),
        .stall     (stall)
    );

endmodule
